// File: rtl/int2flt_seq.sv
// Multi-cycle integer-to-float converter. Produces {sign, exp, mant} with a hidden bit and
// bias 2^(EXP_W-1)-1, normalising the magnitude one bit per cycle. Supports signed or
// unsigned operands, round-to-nearest-even or truncation, and saturation to infinity.
module int2flt_seq #(
  parameter int unsigned INT_W = 16,
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INT_W-1:0]       int_in,
  input  logic                   is_signed,
  input  logic                   rnd_trunc,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   flt_out,
  output logic                   ovf
);

  localparam int unsigned Bias    = 2 ** (EXP_W - 1) - 1;
  localparam int unsigned ExpInit = Bias + INT_W - 1;
  // Counter must reach ExpInit+1 (mantissa carry) and 2^EXP_W for the overflow compare.
  localparam int unsigned ExpNeed = $clog2(ExpInit + 2);
  localparam int unsigned ExpCntW = (ExpNeed > EXP_W + 1) ? ExpNeed : EXP_W + 1;
  localparam int unsigned ExtW    = INT_W + MAN_W;
  localparam int unsigned ExpInf  = 2 ** EXP_W - 1;

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e               state_q;
  logic                 sign_q;
  logic                 rnd_q;
  logic [INT_W-1:0]     mag_q;
  logic [ExpCntW-1:0]   exp_q;
  logic                 busy_q;
  logic                 done_q;
  logic [EXP_W+MAN_W:0] flt_q;
  logic                 ovf_q;

  logic                 sign_in;
  logic [INT_W-1:0]     mag_in;
  logic [ExtW-1:0]      ext;
  logic [MAN_W-1:0]     mant_trunc;
  logic                 guard;
  logic                 sticky;
  logic                 inc;
  logic [MAN_W:0]       mant_sum;
  logic [ExpCntW-1:0]   exp_rnd;
  logic                 ovf_rnd;
  logic [EXP_W+MAN_W:0] flt_rnd;

  // Operand decode at the start edge; the most-negative value negates to 2^(INT_W-1).
  always_comb begin
    sign_in = is_signed & int_in[INT_W-1];
    mag_in  = sign_in ? -int_in : int_in;
  end

  // Rounding datapath on the normalised magnitude; zero padding covers narrow operands.
  always_comb begin
    ext        = {mag_q[INT_W-2:0], {(MAN_W + 1){1'b0}}};
    mant_trunc = ext[ExtW-1 -: MAN_W];
    guard      = ext[INT_W-1];
    sticky     = |ext[INT_W-2:0];
    inc        = ~rnd_q & guard & (sticky | mant_trunc[0]);
    mant_sum   = {1'b0, mant_trunc} + (MAN_W + 1)'(inc);
    exp_rnd    = exp_q + ExpCntW'(mant_sum[MAN_W]);
    ovf_rnd    = exp_rnd >= ExpCntW'(ExpInf);
    if (ovf_rnd) begin
      flt_rnd = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      flt_rnd = {sign_q, exp_rnd[EXP_W-1:0], mant_sum[MAN_W-1:0]};
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      rnd_q   <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            rnd_q  <= rnd_trunc;
            mag_q  <= mag_in;
            exp_q  <= ExpCntW'(ExpInit);
            if (mag_in == '0) begin
              // No negative zero: sign is dropped for a zero operand.
              sign_q  <= 1'b0;
              flt_q   <= '0;
              ovf_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              sign_q  <= sign_in;
              state_q <= StNorm;
            end
          end
        end
        StNorm: begin
          if (!mag_q[INT_W-1]) begin
            mag_q <= {mag_q[INT_W-2:0], 1'b0};
            exp_q <= exp_q - ExpCntW'(1);
          end else begin
            state_q <= StRound;
          end
        end
        StRound: begin
          flt_q   <= flt_rnd;
          ovf_q   <= ovf_rnd;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign flt_out = flt_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_int2flt_seq.sv
// Directed bench for int2flt_seq: default half-precision instance plus a 32-bit/single one.
module tb_int2flt_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        a_start = 1'b0;
  logic [15:0] a_int = '0;
  logic        a_sgn = 1'b0;
  logic        a_trunc = 1'b0;
  logic        a_busy, a_done, a_ovf;
  logic [15:0] a_flt;

  logic        b_start = 1'b0;
  logic [31:0] b_int = '0;
  logic        b_sgn = 1'b0;
  logic        b_trunc = 1'b0;
  logic        b_busy, b_done, b_ovf;
  logic [31:0] b_flt;

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  int2flt_seq dut16 (
    .clk       (clk),
    .reset     (reset),
    .start     (a_start),
    .int_in    (a_int),
    .is_signed (a_sgn),
    .rnd_trunc (a_trunc),
    .busy      (a_busy),
    .done      (a_done),
    .flt_out   (a_flt),
    .ovf       (a_ovf)
  );

  int2flt_seq #(.INT_W(32), .EXP_W(8), .MAN_W(23)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .start     (b_start),
    .int_in    (b_int),
    .is_signed (b_sgn),
    .rnd_trunc (b_trunc),
    .busy      (b_busy),
    .done      (b_done),
    .flt_out   (b_flt),
    .ovf       (b_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion on the 16-bit instance; checks latency, result, flags and hold.
  task automatic conv16(input string tag, input logic [15:0] v, input logic s, input logic t,
                        input logic [15:0] ef, input logic eo, input int en);
    int n;
    @(negedge clk);
    a_int = v; a_sgn = s; a_trunc = t; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    chk({tag, " busy@E0"}, a_busy, 1'b1);
    n = 0;
    while (!a_done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, en);
    chk({tag, " flt"}, a_flt, ef);
    chk({tag, " ovf"}, a_ovf, eo);
    @(posedge clk); #1;
    chk({tag, " done drop"}, a_done, 1'b0);
    chk({tag, " busy drop"}, a_busy, 1'b0);
    chk({tag, " flt hold"}, a_flt, ef);
  endtask

  task automatic conv32(input string tag, input logic [31:0] v, input logic t,
                        input logic [31:0] ef, input int en);
    int n;
    @(negedge clk);
    b_int = v; b_sgn = 1'b1; b_trunc = t; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, en);
    chk({tag, " flt"}, b_flt, ef);
    chk({tag, " ovf"}, b_ovf, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int dcnt;
    logic [15:0] seen;
    #2 reset = 1'b0;
    #1;
    chk("rst busy", a_busy, 1'b0);
    chk("rst done", a_done, 1'b0);
    chk("rst flt", a_flt, 16'h0000);
    chk("rst ovf", a_ovf, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    conv16("s0001", 16'h0001, 1'b1, 1'b0, 16'h3C00, 1'b0, 17);
    conv16("zero", 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 0);
    conv16("s4F00", 16'h4F00, 1'b1, 1'b0, 16'h74F0, 1'b0, 3);
    conv16("sFFC0", 16'hFFC0, 1'b1, 1'b0, 16'hD400, 1'b0, 11);
    conv16("s8000", 16'h8000, 1'b1, 1'b0, 16'hF800, 1'b0, 2);
    conv16("u8000", 16'h8000, 1'b0, 1'b0, 16'h7800, 1'b0, 2);
    conv16("s7FF0", 16'h7FF0, 1'b1, 1'b0, 16'h77FF, 1'b0, 3);
    conv16("s7FF8 rne", 16'h7FF8, 1'b1, 1'b0, 16'h7800, 1'b0, 3);
    conv16("s7FF8 trn", 16'h7FF8, 1'b1, 1'b1, 16'h77FF, 1'b0, 3);
    conv16("uFFFF rne", 16'hFFFF, 1'b0, 1'b0, 16'h7C00, 1'b1, 2);
    conv16("uFFFF trn", 16'hFFFF, 1'b0, 1'b1, 16'h7BFF, 1'b0, 2);

    // Start held high through a conversion; operand changes right after E0.
    @(negedge clk);
    a_int = 16'h4F00; a_sgn = 1'b1; a_trunc = 1'b0; a_start = 1'b1;
    @(posedge clk); #1;
    a_int = 16'h0001;
    dcnt = 0;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_done) begin
        dcnt++;
        seen = a_flt;
      end
    end
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_done) dcnt++;
    end
    chk("hold done count", dcnt, 1);
    chk("hold flt", seen, 16'h74F0);

    // Reset in the middle of a long conversion.
    @(negedge clk);
    a_int = 16'h0001; a_sgn = 1'b1; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", a_busy, 1'b0);
    chk("abort done", a_done, 1'b0);
    chk("abort flt", a_flt, 16'h0000);
    chk("abort ovf", a_ovf, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (a_done) dcnt++;
    end
    chk("abort no done", dcnt, 0);
    conv16("post rst", 16'hFFC0, 1'b1, 1'b0, 16'hD400, 1'b0, 11);

    conv32("w32 rne", 32'h7FFFFFFF, 1'b0, 32'h4F000000, 3);
    conv32("w32 trn", 32'h7FFFFFFF, 1'b1, 32'h4EFFFFFF, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/int2flt_seq.md
Name: int2flt_seq

Overview:
- Parametrised multi-cycle converter from an INT_W-bit integer to a sign/EXP_W/MAN_W binary float with hidden bit and bias 2^(EXP_W-1)-1.
- Successor to the fixed 16-bit-to-half converter. Adds an unsigned mode, a selectable rounding mode and overflow-to-infinity.
- Takes operands directly on ports with a start/done handshake and normalises one bit per cycle, so area stays small.
- Sits beside the data memory. The controller loads int_in, pulses start, waits for done, then stores flt_out.

Parameters:
- INT_W, 16, integer input width; must be at least 2.
- EXP_W, 5, exponent field width; bias BIAS = 2^(EXP_W-1)-1.
- MAN_W, 10, stored mantissa width; the hidden bit is not stored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- int_in  in  INT_W  operand; sampled on the start edge.
- is_signed  in  1  1 = two's complement, 0 = unsigned; sampled on the start edge.
- rnd_trunc  in  1  0 = round-to-nearest-even, 1 = truncate; sampled on the start edge.
- busy  out  1  high from the start edge until done drops.
- done  out  1  one-cycle pulse when flt_out is valid.
- flt_out  out  1+EXP_W+MAN_W  result as {sign, exp, mant}; held until the next done.
- ovf  out  1  result saturated to infinity; valid with done, held with flt_out.

Behaviour:
- Reset (reset low, asynchronous): state goes to IDLE. busy=0, done=0, flt_out=0, ovf=0. All internal registers clear. Reset mid-conversion aborts it: no done, old result lost.
- States: IDLE, NORM, ROUND, DONE.
- IDLE with start=1 (edge E0):
  - Latch sign = is_signed & int_in[INT_W-1]; magnitude = sign ? -int_in : int_in, held INT_W bits wide.
  - Most-negative signed input: magnitude = 2^(INT_W-1), which fits unsigned.
  - Latch rnd_trunc. Set exp counter = BIAS+INT_W-1; the counter is wide enough to hold 2^EXP_W.
  - magnitude==0 -> DONE with flt_out=0. Sign is forced to 0; there is no negative zero.
  - Otherwise -> NORM.
- start while busy is ignored; there is no queueing.
- NORM:
  - If magnitude[INT_W-1]==0: shift magnitude left 1, decrement exp, stay in NORM.
  - Otherwise -> ROUND.
- ROUND:
  - mant = the MAN_W bits below the MSB, zero-padded on the right if INT_W-1 < MAN_W.
  - guard = next lower bit; sticky = OR of all remaining lower bits; guard and sticky are 0 when no bits remain.
  - RNE increments mant when guard & (sticky | mant[0]). Truncate never increments.
  - Mantissa carry-out: mant = 0, exp += 1.
  - If exp >= 2^EXP_W-1: flt_out = {sign, all-ones, 0}, ovf=1. Otherwise flt_out = {sign, exp[EXP_W-1:0], mant}, ovf=0.
  - -> DONE.
- DONE: done=1 for exactly one cycle, busy stays 1, then -> IDLE. A start in the DONE cycle is ignored.
- Latency: let lz = leading zeros of the INT_W-bit magnitude. done is high in the cycle beginning at edge E0+N:
  - N=0 for a zero operand.
  - N=lz+2 otherwise.
  - Maximum N = INT_W+1.
- flt_out and ovf update only on entry to DONE. They are stable from done until the next result.
- Subnormal outputs are never produced, since the minimum nonzero magnitude 1 maps to exp = BIAS.

Test Plan:
- Defaults, is_signed=1, int_in=0x0001 -> flt_out=0x3C00, ovf=0, done at E0+17. Then int_in=0x0000 -> flt_out=0x0000, done at E0+0.
- Signed 0x4F00 -> 0x74F0 at E0+3. Signed 0xFFC0 -> 0xD400. Signed 0x8000 -> 0xF800. Unsigned 0x8000 -> 0x7800 at E0+2.
- Signed 0x7FF0 -> 0x77FF. Signed 0x7FF8, RNE -> 0x7800 (mantissa carry bumps exp). Signed 0x7FF8, truncate -> 0x77FF.
- Unsigned 0xFFFF, RNE -> 0x7C00, ovf=1. Unsigned 0xFFFF, truncate -> 0x7BFF, ovf=0.
- Hold start high through a whole conversion with int_in changing after E0 -> exactly one done with the E0 operand's result. Then drop reset low at E0+5 of a new 0x0001 conversion -> all outputs 0 immediately, no done, next start converts normally.
- INT_W=32, EXP_W=8, MAN_W=23, signed 0x7FFFFFFF, RNE -> 0x4F000000. Same operand, truncate -> 0x4EFFFFFF.
